// File: rtl/nabp_shifter.sv
`default_nettype none
// ============================================================================
// Module      : nabp_shifter
// Description : Per-projection-line sequencer: kicks the mapper, waits out the
//               line-buffer fill latency, then issues kImageSize PE shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module nabp_shifter #(
  parameter  int kImageSize   = 128,
  parameter  int kFillDelay   = 2,
  parameter  int kAngleLength = 9,
  localparam int CNT_W        = $clog2(kImageSize + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sc_kick,
  input  logic [kAngleLength-1:0] sc_angle,
  output logic                    sh_ready,
  output logic [kAngleLength-1:0] sh_angle,
  output logic                    sh_kick,
  output logic                    sh_shift_en,
  output logic                    sh_done,
  input  logic                    pe_stall,
  output logic [CNT_W-1:0]        sh_shift_count
);

  localparam logic [2:0] READY_S = 3'd0;
  localparam logic [2:0] KICK_S  = 3'd1;
  localparam logic [2:0] FILL_S  = 3'd2;
  localparam logic [2:0] SHIFT_S = 3'd3;
  localparam logic [2:0] DONE_S  = 3'd4;

  // Fill counter keeps at least one bit so a zero-delay build still elaborates.
  localparam int               FILL_W    = (kFillDelay > 0) ? $clog2(kFillDelay + 1) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((kFillDelay > 0) ? kFillDelay - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(kImageSize - 1);

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [FILL_W-1:0]       fill_q,  fill_d;
  logic [kAngleLength-1:0] angle_q, angle_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    angle_d = angle_q;
    case (state_q)
      READY_S: begin
        if (sc_kick) begin
          angle_d = sc_angle;
          cnt_d   = '0;
          fill_d  = '0;
          state_d = KICK_S;
        end
      end
      KICK_S: begin
        state_d = (kFillDelay == 0) ? SHIFT_S : FILL_S;
      end
      FILL_S: begin
        if (fill_q == FILL_LAST) begin
          state_d = SHIFT_S;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      SHIFT_S: begin
        // A stall freezes both the count and the exit, even on the last shift.
        if (!pe_stall) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE_S;
          end
        end
      end
      DONE_S: begin
        state_d = READY_S;
      end
      default: begin
        state_d = READY_S;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= READY_S;
      cnt_q   <= '0;
      fill_q  <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      angle_q <= angle_d;
    end
  end

  assign sh_ready       = (state_q == READY_S);
  assign sh_kick        = (state_q == KICK_S);
  assign sh_shift_en    = (state_q == SHIFT_S) && !pe_stall;
  assign sh_done        = (state_q == DONE_S);
  assign sh_angle       = angle_q;
  assign sh_shift_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nabp_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nabp_shifter
// Description : Vector-table and scoreboard bench for nabp_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nabp_shifter;

  localparam int IMG = 4;
  localparam int ANG = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic           sc_kick;
  logic [ANG-1:0] sc_angle;
  logic           pe_stall;
  logic           sh_ready, sh_kick, sh_shift_en, sh_done;
  logic [ANG-1:0] sh_angle;
  logic [2:0]     sh_shift_count;

  logic           kick0;
  logic [ANG-1:0] angle0;
  logic           stall0;
  logic           rdy0, kck0, sh0, dn0;
  logic [ANG-1:0] ang0;
  logic [2:0]     cnt0;

  always #5 clk = ~clk;

  nabp_shifter #(.kImageSize(IMG), .kFillDelay(2), .kAngleLength(ANG)) dut (
    .clk(clk), .reset(reset), .sc_kick(sc_kick), .sc_angle(sc_angle),
    .sh_ready(sh_ready), .sh_angle(sh_angle), .sh_kick(sh_kick),
    .sh_shift_en(sh_shift_en), .sh_done(sh_done), .pe_stall(pe_stall),
    .sh_shift_count(sh_shift_count)
  );

  nabp_shifter #(.kImageSize(IMG), .kFillDelay(0), .kAngleLength(ANG)) dut_nofill (
    .clk(clk), .reset(reset), .sc_kick(kick0), .sc_angle(angle0),
    .sh_ready(rdy0), .sh_angle(ang0), .sh_kick(kck0),
    .sh_shift_en(sh0), .sh_done(dn0), .pe_stall(stall0),
    .sh_shift_count(cnt0)
  );

  typedef struct {
    logic           rdy;
    logic           kck;
    logic           sh;
    logic           dn;
    logic [2:0]     cnt;
    logic [ANG-1:0] ang;
  } exp_t;

  typedef struct {
    logic           kick;
    logic [ANG-1:0] angle;
    logic           stall;
    exp_t           e;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic k, input int a, input logic s,
                     input logic r, input logic kk, input logic sh, input logic dn,
                     input int cnt, input int ang);
    vec_t v;
    v.kick  = k;
    v.angle = ANG'(a);
    v.stall = s;
    v.e.rdy = r;
    v.e.kck = kk;
    v.e.sh  = sh;
    v.e.dn  = dn;
    v.e.cnt = 3'(cnt);
    v.e.ang = ANG'(ang);
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input exp_t e);
    checks++;
    if (sh_ready !== e.rdy || sh_kick !== e.kck || sh_shift_en !== e.sh ||
        sh_done !== e.dn || sh_shift_count !== e.cnt || sh_angle !== e.ang) begin
      errors++;
      $display("FAIL %s: got rdy=%b kick=%b shen=%b done=%b cnt=%0d ang=%0d, want rdy=%b kick=%b shen=%b done=%b cnt=%0d ang=%0d",
               name, sh_ready, sh_kick, sh_shift_en, sh_done, sh_shift_count, sh_angle,
               e.rdy, e.kck, e.sh, e.dn, e.cnt, e.ang);
    end
  endtask

  initial begin
    exp_t e;
    int   done_at;

    reset = 1'b1; sc_kick = 1'b0; sc_angle = '0; pe_stall = 1'b0;
    kick0 = 1'b0; angle0 = '0; stall0 = 1'b0;

    // Line A: no stalls, angle 37 (cycles 0..9)
    add(1, 37, 0,  1, 0, 0, 0, 0,  0);
    add(0,  0, 0,  0, 1, 0, 0, 0, 37);
    add(0,  0, 0,  0, 0, 0, 0, 0, 37);
    add(0,  0, 0,  0, 0, 0, 0, 0, 37);
    add(0,  0, 0,  0, 0, 1, 0, 0, 37);
    add(0,  0, 0,  0, 0, 1, 0, 1, 37);
    add(0,  0, 0,  0, 0, 1, 0, 2, 37);
    add(0,  0, 0,  0, 0, 1, 0, 3, 37);
    add(0,  0, 0,  0, 0, 0, 1, 4, 37);
    add(0,  0, 0,  1, 0, 0, 0, 4, 37);
    // Line B: stall through fill (ignored), stall at cycles 5-6, stray kick 99
    add(1, 37, 0,  1, 0, 0, 0, 4, 37);
    add(0,  0, 0,  0, 1, 0, 0, 0, 37);
    add(0,  0, 1,  0, 0, 0, 0, 0, 37);
    add(0,  0, 1,  0, 0, 0, 0, 0, 37);
    add(0,  0, 0,  0, 0, 1, 0, 0, 37);
    add(0,  0, 1,  0, 0, 0, 0, 1, 37);
    add(1, 99, 1,  0, 0, 0, 0, 1, 37);
    add(0,  0, 0,  0, 0, 1, 0, 1, 37);
    add(0,  0, 0,  0, 0, 1, 0, 2, 37);
    add(0,  0, 0,  0, 0, 1, 0, 3, 37);
    add(0,  0, 0,  0, 0, 0, 1, 4, 37);
    // Line C: stall on the final shift, kick during done ignored, kick on ready taken
    add(1, 200, 0, 1, 0, 0, 0, 4, 37);
    add(0,  0, 0,  0, 1, 0, 0, 0, 200);
    add(0,  0, 0,  0, 0, 0, 0, 0, 200);
    add(0,  0, 0,  0, 0, 0, 0, 0, 200);
    add(0,  0, 0,  0, 0, 1, 0, 0, 200);
    add(0,  0, 0,  0, 0, 1, 0, 1, 200);
    add(0,  0, 0,  0, 0, 1, 0, 2, 200);
    add(0,  0, 1,  0, 0, 0, 0, 3, 200);
    add(0,  0, 0,  0, 0, 1, 0, 3, 200);
    add(1, 55, 0,  0, 0, 0, 1, 4, 200);
    add(1, 55, 0,  1, 0, 0, 0, 4, 200);
    add(0,  0, 0,  0, 1, 0, 0, 0, 55);
    add(0,  0, 0,  0, 0, 0, 0, 0, 55);
    add(0,  0, 0,  0, 0, 0, 0, 0, 55);
    add(0,  0, 0,  0, 0, 1, 0, 0, 55);
    add(0,  0, 0,  0, 0, 1, 0, 1, 55);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #5;
    e = '{rdy: 1'b1, kck: 1'b0, sh: 1'b0, dn: 1'b0, cnt: 3'd0, ang: '0};
    check_out("reset_state", e);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      sc_kick  = vecs[i].kick;
      sc_angle = vecs[i].angle;
      pe_stall = vecs[i].stall;
      exp_q.push_back(vecs[i].e);
      #5;
      e = exp_q.pop_front();
      check_out($sformatf("row%0d", i), e);
    end

    // Asynchronous reset in the middle of line C's shift phase
    sc_kick = 1'b0; pe_stall = 1'b0;
    #1 reset = 1'b1;
    #1;
    e = '{rdy: 1'b1, kck: 1'b0, sh: 1'b0, dn: 1'b0, cnt: 3'd0, ang: '0};
    check_out("async_reset", e);

    @(posedge clk);
    #1;
    reset    = 1'b0;
    sc_kick  = 1'b1;
    sc_angle = 9'd5;
    #5;
    check_out("post_reset_idle", e);

    done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1 sc_kick = 1'b0;
      #5;
      if (c == 1) begin
        e = '{rdy: 1'b0, kck: 1'b1, sh: 1'b0, dn: 1'b0, cnt: 3'd0, ang: 9'd5};
        check_out("restart_kick", e);
      end
      if (sh_done && done_at < 0) begin
        done_at = c;
        break;
      end
    end
    checks++;
    if (done_at != 8 || sh_shift_count !== 3'd4) begin
      errors++;
      $display("FAIL restart_latency: got done_cycle=%0d cnt=%0d, want done_cycle=8 cnt=4",
               done_at, sh_shift_count);
    end

    // Zero fill-delay build
    @(posedge clk);
    #1;
    kick0  = 1'b1;
    angle0 = 9'd3;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1 kick0 = 1'b0;
      end
      #5;
      checks++;
      if (kck0 !== (c == 1) || sh0 !== (c >= 2 && c <= 5) || dn0 !== (c == 6) ||
          rdy0 !== (c == 0 || c == 7)) begin
        errors++;
        $display("FAIL nofill_c%0d: got rdy=%b kick=%b shen=%b done=%b, want rdy=%b kick=%b shen=%b done=%b",
                 c, rdy0, kck0, sh0, dn0, (c == 0 || c == 7), (c == 1), (c >= 2 && c <= 5), (c == 6));
      end
    end
    checks++;
    if (cnt0 !== 3'd4 || ang0 !== 9'd3) begin
      errors++;
      $display("FAIL nofill_final: got cnt=%0d ang=%0d, want cnt=4 ang=3", cnt0, ang0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nabp_shifter.md
NABP_SHIFTER -- requirements
Module: nabp_shifter

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset, ports clk and reset; no other clock or reset inputs.
REQ-002 Parameter kImageSize, default 128: shifts per projection line; legal range 2..4096.
REQ-003 Parameter kFillDelay, default 2: idle cycles between sh_kick and the first shift, covering mapper-to-line-buffer latency; legal range 0..15.
REQ-004 Parameter kAngleLength, default 9: angle word width.
REQ-005 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous active-high reset.
REQ-007 Port sc_kick, input, 1: state-control request to process one projection line.
REQ-008 Port sc_angle, input, kAngleLength: angle of the requested line; sampled only on an accepted sc_kick.
REQ-009 Port sh_ready, output, 1: block idle; sc_kick is accepted this cycle.
REQ-010 Port sh_angle, output, kAngleLength: latched angle of the line in progress.
REQ-011 Port sh_kick, output, 1: one-cycle pulse that starts the mapper.
REQ-012 Port sh_shift_en, output, 1: one PE-array shift and one mapper accumulate step this cycle.
REQ-013 Port sh_done, output, 1: one-cycle pulse marking the line complete.
REQ-014 Port pe_stall, input, 1: downstream back-pressure; suppresses shifting.
REQ-015 Port sh_shift_count, output, clog2(kImageSize+1): shifts completed on the current line.

Function
REQ-016 The FSM SHALL have states ready_s, kick_s, fill_s, shift_s and done_s, held in a registered state updated every clk.
REQ-017 In ready_s, sh_ready=1; sc_kick=1 SHALL latch sc_angle into sh_angle, clear the counters and move to kick_s.
REQ-018 sc_kick SHALL be ignored in any state other than ready_s.
REQ-019 kick_s SHALL last exactly one cycle with sh_kick=1, then move to fill_s; if kFillDelay=0 it moves directly to shift_s.
REQ-020 fill_s SHALL last exactly kFillDelay cycles, with sh_shift_en=0 and pe_stall ignored, then move to shift_s.
REQ-021 In shift_s, sh_shift_en SHALL equal !pe_stall combinationally; sh_shift_count increments by 1 on every cycle in which sh_shift_en=1.
REQ-022 When sh_shift_en=1 and sh_shift_count=kImageSize-1, the next state SHALL be done_s and sh_shift_count becomes kImageSize.
REQ-023 While pe_stall=1 in shift_s, the state and sh_shift_count SHALL hold, including on the final shift.
REQ-024 done_s SHALL last exactly one cycle with sh_done=1, then return to ready_s; sh_shift_count holds kImageSize until the next accepted sc_kick.
REQ-025 sh_kick, sh_shift_en and sh_done SHALL be mutually exclusive and 0 outside their states.
REQ-026 Line latency, sc_kick to sh_done with no stalls: 1 + 1 + kFillDelay + kImageSize cycles; sh_done occurs 1+kFillDelay+kImageSize cycles after sh_kick.
REQ-027 The earliest next sc_kick acceptance SHALL be the cycle after done_s, so there is no back-to-back overlap of lines.
REQ-028 Counter arithmetic SHALL be unsigned with no wrap: sh_shift_count never exceeds kImageSize, and the fill counter never exceeds kFillDelay.

Reset
REQ-029 Asserting reset SHALL immediately force state to ready_s, sh_shift_count=0, sh_angle=0 and the fill counter to 0, giving sh_kick=sh_shift_en=sh_done=0 and sh_ready=1.
REQ-030 Reset asserted mid-line SHALL abandon the line without an sh_done pulse.
REQ-031 After reset deasserts, the first rising edge SHALL process sc_kick normally.

Verification (kImageSize=4, kFillDelay=2, kAngleLength=9)
REQ-032 sc_kick=1, sc_angle=37 at cycle 0, no stall -> sh_kick at cycle 1; sh_shift_en at cycles 4-7; sh_done at cycle 8; sh_angle=37; sh_ready=1 at cycle 9.
REQ-033 Same stimulus with pe_stall=1 at cycles 5-6 -> sh_shift_en at cycles 4, 7, 8, 9; sh_shift_count sequence 1,1,1,2,3,4; sh_done at cycle 10.
REQ-034 pe_stall held high for the whole fill_s -> no effect; first sh_shift_en at cycle 4.
REQ-035 sc_kick pulsed with sc_angle=99 during shift_s -> ignored; sh_angle stays 37 and the line completes unchanged.
REQ-036 reset asserted asynchronously at cycle 5.5 -> outputs reach reset values before the cycle-6 edge; no sh_done; a new sc_kick after release restarts at count 0.
REQ-037 Rebuild with kFillDelay=0: sc_kick at cycle 0 -> sh_kick at 1, sh_shift_en at cycles 2-5, sh_done at 6.
